// File: rtl/tron_direction_ctrl.sv
// Tron player direction control: key sync/edge detect, reverse blocking, paced step strobe.
// Optional TURN_BUFFER_EN turns the single pending slot into a 2-entry turn FIFO.
module tron_direction_ctrl #(
    parameter int unsigned TICK_DIV = 833333,
    parameter logic [1:0]  INIT_DIR = 2'b01
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       start,
    input  logic       restart,
    input  logic       crash,
    output logic [1:0] direction,
    output logic       step,
    output logic       coord_reset,
    output logic       running
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CRASHED
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    keys_prev;
    logic [3:0]    rise;
    logic          req_valid;
    logic [1:0]    req_dir;
    logic [CW-1:0] count;
    logic          tick;
    logic          commit;
    logic          flush;
    logic          head_valid;
    logic [1:0]    head_dir;

    // key vectors are ordered {up, down, left, right}
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1     <= '0;
            sync2     <= '0;
            keys_prev <= '0;
        end else begin
            sync1     <= {key_up, key_down, key_left, key_right};
            sync2     <= sync1;
            keys_prev <= sync2;
        end
    end

    assign rise      = sync2 & ~keys_prev;
    assign req_valid = |rise;

    always_comb begin
        req_dir = 2'b00;
        if (rise[3])      req_dir = 2'b10;
        else if (rise[2]) req_dir = 2'b00;
        else if (rise[1]) req_dir = 2'b11;
        else if (rise[0]) req_dir = 2'b01;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (crash) state_nx = CRASHED;
            CRASHED: state_nx = CRASHED;
            default: state_nx = IDLE;
        endcase
        if (restart) state_nx = IDLE;
    end

    assign running = (state == RUN);
    assign tick    = (state == RUN) && (count == LAST);
    // a crash or restart on the tick edge suppresses the commit
    assign commit  = tick && (state_nx == RUN);
    assign flush   = restart || (state_nx == CRASHED);

`ifdef TURN_BUFFER_EN
    logic [1:0] q0;
    logic [1:0] q1;
    logic [1:0] used;
    logic [1:0] q0_nx;
    logic [1:0] q1_nx;
    logic [1:0] used_nx;

    always_comb begin
        q0_nx   = q0;
        q1_nx   = q1;
        used_nx = used;
        if (commit && used != 2'd0) begin
            q0_nx   = q1;
            used_nx = used - 2'd1;
        end
        if (req_valid) begin
            if (used_nx == 2'd0) begin
                q0_nx   = req_dir;
                used_nx = 2'd1;
            end else begin
                q1_nx   = req_dir;
                used_nx = 2'd2;
            end
        end
        if (flush) used_nx = 2'd0;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            q0   <= 2'b00;
            q1   <= 2'b00;
            used <= 2'd0;
        end else begin
            q0   <= q0_nx;
            q1   <= q1_nx;
            used <= used_nx;
        end
    end

    assign head_valid = (used != 2'd0);
    assign head_dir   = q0;
`else
    logic       pend_valid;
    logic [1:0] pend_dir;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pend_valid <= 1'b0;
            pend_dir   <= 2'b00;
        end else if (flush) begin
            pend_valid <= 1'b0;
        end else if (req_valid) begin
            pend_valid <= 1'b1;
            pend_dir   <= req_dir;
        end else if (commit) begin
            pend_valid <= 1'b0;
        end
    end

    assign head_valid = pend_valid;
    assign head_dir   = pend_dir;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            count       <= '0;
            direction   <= INIT_DIR;
            step        <= 1'b0;
            coord_reset <= 1'b0;
        end else begin
            step        <= commit;
            coord_reset <= restart;
            if (state == RUN && state_nx == RUN)
                count <= tick ? '0 : count + CW'(1);
            else
                count <= '0;
            if (restart)
                direction <= INIT_DIR;
            else if (commit && head_valid && head_dir != (direction ^ 2'b10))
                direction <= head_dir;
        end
    end

endmodule

// File: doc/tron_direction_ctrl.md
Name: tron_direction_ctrl

Overview:
- Upstream stage of the per-player coordinate register.
- Turns raw player keys into a legal 2-bit travel direction and a one-cycle movement strobe.
- Paces movement with an internal rate divider and blocks 180-degree reversals.
- Tracks game run/crash state so the coordinate register only advances while a round is live.

Parameters:
TICK_DIV, 833333, CLOCK_50 cycles per movement step (60 steps/s at 50 MHz); minimum 2
INIT_DIR, 2'b01, direction loaded at reset/restart (00 down y+1, 01 right x+1, 10 up y-1, 11 left x-1)

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous reset, active-low
key_up  in  1  raw up key, active-high, asynchronous to CLOCK_50
key_down  in  1  raw down key, active-high
key_left  in  1  raw left key, active-high
key_right  in  1  raw right key, active-high
start  in  1  synchronous pulse/level: IDLE -> RUN
restart  in  1  synchronous: reload INIT_DIR, clear pending, go to IDLE
crash  in  1  synchronous, from downstream collision logic: RUN -> CRASHED
direction  out  2  committed direction, fed to the coordinate register
step  out  1  one-cycle strobe; coordinate register advances only when high
coord_reset  out  1  one-cycle pulse on restart, reloads the coordinate register's initial position
running  out  1  high in RUN

Behaviour:
- Reset (resetn low, asynchronous), all registers cleared:
  - direction=INIT_DIR, step=0, coord_reset=0, running=0.
  - state=IDLE, divider=0, pending empty, synchronisers 0.
- Key input path:
  - Each key passes through a 2-flop synchroniser, then a rising-edge detect.
  - A key rise is visible as a pending request 3 cycles after the raw key rises.
  - Same-cycle rises resolve by priority up > down > left > right.
  - A new request overwrites any existing pending request (single slot).
- Legality:
  - A request equal to direction XOR 2'b10 (reverse) is discarded at commit time.
  - A request equal to the current direction is accepted as a no-op.
- Divider:
  - Counts 0..TICK_DIV-1 only in RUN; holds at 0 in IDLE and CRASHED.
  - tick = (count == TICK_DIV-1); count wraps to 0 on the same edge.
- Commit, on the tick edge:
  - If pending is legal: direction <= pending.
  - Pending is cleared whether or not it was legal.
  - step <= 1.
  - In the following cycle, step=1 and direction already shows the new value. step is never high two consecutive cycles.
- State machine (IDLE, RUN, CRASHED):
  - IDLE: step=0; key requests are still captured (pre-aim allowed, legality judged vs INIT_DIR). start -> RUN, divider from 0.
  - RUN: running=1. crash -> CRASHED on that edge. If crash and tick coincide, crash wins: no step, no commit.
  - CRASHED: direction frozen, step=0, key requests ignored and pending cleared.
  - restart from any state:
    - -> IDLE, direction=INIT_DIR, pending cleared, divider=0.
    - coord_reset=1 for exactly one cycle, the cycle after restart is sampled.
  - Precedence: restart > crash > start.
- Held keys do not re-request; a new press requires release and re-press.
- An asynchronous resetn mid-step clears step immediately.

Optional Feature:
TURN_BUFFER_EN
- Defined: pending becomes a 2-entry FIFO; a third press while full overwrites the newest entry.
  - One entry commits per tick.
  - Legality is checked against the direction in force at that entry's commit.
  - This lets a quick down-then-left U-turn execute on consecutive ticks.
- Undefined: single overwrite slot as above.
- Restart/crash clear all entries.

Test Plan:
- Bring-up:
  - Stimulus: TICK_DIV=4, resetn low then high, start pulse.
  - Response: direction=01; step high once every 4 cycles; running=1.
- Turn:
  - Stimulus: in RUN with direction=01, raise key_up.
  - Response: direction becomes 10 with the first step at least 3 cycles after the press.
- Reverse rejection:
  - Stimulus: direction=01, press key_left.
  - Response: at the next step direction stays 01 and pending clears.
  - Then press key_down: next step gives 00.
- Crash coinciding with tick:
  - Stimulus: crash asserted on the tick cycle.
  - Response: no step pulse, state CRASHED; later key presses do not change direction.
- Restart:
  - Stimulus: restart in CRASHED.
  - Response: coord_reset high exactly 1 cycle, direction=01, running=0; after a new start, the first step comes 4 cycles later.
- Buffer (TURN_BUFFER_EN):
  - Stimulus: direction=01, press down then left within one tick period.
  - Response: next two steps show 00 then 11.
  - Without the macro: only 11, rejected as a reverse of 01, so direction stays 01.
